eth_frame_parser: RTL and testbench
===================================

ETH_FRAME_PARSER -- requirements
Module: eth_frame_parser

Interface
REQ-001 SHALL have no parameters; widths come from soc_defs.vh (MAC_INTERFACE_W=512, MAC_PADBYTES_W=6, MTU_SIZE_W).
REQ-002 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-003 mac_parse_val / mac_parse_data[MAC_INTERFACE_W] / mac_parse_last / mac_parse_padbytes[MAC_PADBYTES_W]  in  raw frame beats, byte 0 in MSBs.
REQ-004 mac_parse_frame_size  in  MTU_SIZE_W  total frame bytes incl. 14B header, valid with first beat.
REQ-005 parse_mac_rdy  out  1  beat accepted when val&rdy.
REQ-006 parse_dst_eth_hdr  out  eth_hdr; parse_dst_data_size  out  MTU_SIZE_W; parse_dst_timestamp  out  tracker_stats_struct; parse_dst_hdr_val  out  1; dst_parse_hdr_rdy  in  1.
REQ-007 parse_dst_data_val / _data / _last / _padbytes  out  payload stream, header stripped, realigned to byte 0; dst_parse_data_rdy  in  1.
REQ-008 parse_drop_cnt  out  32  count of dropped runt frames.

Function
REQ-009 SHALL own a 64-bit free-running cycle counter; timestamp = counter value on cycle first beat accepted, zero-extended/truncated into tracker_stats_struct.
REQ-010 States: IDLE, HDR_OUT, DATA, DRAIN.
REQ-011 IDLE: parse_mac_rdy=1; on first beat accept, latch eth_hdr (bytes 0..13), data_size=frame_size-14, timestamp, residue = bytes 14..63, first-beat valid bytes V=64-padbytes; -> HDR_OUT.
REQ-012 IDLE runt: first beat with last=1 and V<=14 SHALL be dropped, drop_cnt+1, stay IDLE, no hdr/data output.
REQ-013 HDR_OUT: hdr_val=1 from registered values, parse_mac_rdy=0; on hdr_rdy -> DRAIN if first beat was last, else DATA.
REQ-014 Header latency: hdr_val asserted exactly one cycle after first-beat accept when no stall.
REQ-015 DATA: out_val=mac_parse_val, parse_mac_rdy=dst_parse_data_rdy (combinational pass); out_data = residue(50B) ++ input bytes 0..13; on transfer residue <= input bytes 14..63.
REQ-016 DATA, input last with V<=14: out_last=1, out_padbytes=14-V, -> IDLE.
REQ-017 DATA, input last with V>14: out_last=0 (full beat), residue V-14 bytes, -> DRAIN.
REQ-018 DRAIN: out_val=1, parse_mac_rdy=0, data=residue left-aligned, last=1, padbytes=64-(V-14)=78-V; on rdy -> IDLE.
REQ-019 Output data/padbytes SHALL be held stable while val=1 and rdy=0; val never deasserts before transfer except via rst.
REQ-020 Total payload bytes emitted SHALL equal sum of input valid bytes minus 14.
REQ-021 Header and data channels independent; no data beat before header accepted.
REQ-022 drop_cnt wraps at 2^32-1 -> 0.

Reset
REQ-023 rst SHALL force IDLE, all val outputs 0, parse_mac_rdy 1 next cycle, drop_cnt 0, cycle counter 0, residue/header regs 0.
REQ-024 rst mid-frame SHALL abandon the frame; remaining beats of it after reset are treated as a new frame's first beat (upstream must also reset).

Structure
REQ-025 ETH_HDR_BYTES=14 and state enum SHALL live in a shared eth_parse_pkg; eth_hdr from packet_struct_pkg, tracker_stats_struct from tracker_pkg.
REQ-026 Single flat module; no sub-module (realignment is inline byte-slice muxing).

Verification
REQ-027 Single-beat frame 60B (padbytes=4, frame_size=60) -> hdr (size 46) then one beat, last=1, padbytes=18.
REQ-028 Two-beat frame 128B (padbytes 0,0) -> beat0 full, DRAIN beat last=1 with 50 valid bytes (padbytes=14).
REQ-029 Two-beat frame 74B (second beat V=10) -> single output beat last=1, padbytes=4, 60 payload bytes correct order.
REQ-030 Runt: one beat last=1, padbytes=52 (V=12) -> no outputs, drop_cnt=1.
REQ-031 Random hdr_rdy/data_rdy backpressure on 1518B frames -> payload byte-exact, outputs stable while stalled, timestamp = first-beat cycle.
REQ-032 rst asserted in DATA mid 1518B frame -> next cycle IDLE, all val=0, rdy=1; following clean 60B frame parsed correctly.

Source files
------------

// File: rtl/eth_parse_pkg.sv
// Shared types for the Ethernet frame parser: SoC-wide widths, header/timestamp
// records and the parser state encoding.
package tracker_pkg;
  typedef struct packed {
    logic [47:0] rx_cycle;
  } tracker_stats_struct;
endpackage

package packet_struct_pkg;
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
  } eth_hdr;
endpackage

package eth_parse_pkg;
  // SoC interface widths, shared with the MAC and downstream consumers.
  localparam int MAC_INTERFACE_W = 512;
  localparam int MAC_PADBYTES_W  = 6;
  localparam int MTU_SIZE_W      = 14;

  localparam int MAC_BYTES     = MAC_INTERFACE_W / 8;
  localparam int ETH_HDR_BYTES = 14;
  localparam int RESIDUE_BYTES = MAC_BYTES - ETH_HDR_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR_OUT,
    ST_DATA,
    ST_DRAIN
  } parse_state_e;
endpackage

// File: rtl/eth_frame_parser.sv
// Strips the 14-byte Ethernet header from a 64-byte-wide MAC stream, presents it
// on a header channel and re-aligns the payload so it starts at byte 0.
module eth_frame_parser
  import eth_parse_pkg::*;
  import packet_struct_pkg::*;
  import tracker_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mac_parse_val,
  input  logic [MAC_INTERFACE_W-1:0] mac_parse_data,
  input  logic                      mac_parse_last,
  input  logic [MAC_PADBYTES_W-1:0] mac_parse_padbytes,
  input  logic [MTU_SIZE_W-1:0]     mac_parse_frame_size,
  output logic                      parse_mac_rdy,
  output eth_hdr                    parse_dst_eth_hdr,
  output logic [MTU_SIZE_W-1:0]     parse_dst_data_size,
  output tracker_stats_struct       parse_dst_timestamp,
  output logic                      parse_dst_hdr_val,
  input  logic                      dst_parse_hdr_rdy,
  output logic                      parse_dst_data_val,
  output logic [MAC_INTERFACE_W-1:0] parse_dst_data,
  output logic                      parse_dst_data_last,
  output logic [MAC_PADBYTES_W-1:0] parse_dst_padbytes,
  input  logic                      dst_parse_data_rdy,
  output logic [31:0]               parse_drop_cnt
);

  localparam int HDR_W = ETH_HDR_BYTES * 8;
  localparam int RES_W = RESIDUE_BYTES * 8;
  localparam int TS_W  = $bits(tracker_stats_struct);

  parse_state_e         state_q, state_d;
  eth_hdr               hdr_q, hdr_d;
  logic [MTU_SIZE_W-1:0] size_q, size_d;
  tracker_stats_struct  ts_q, ts_d;
  logic [RES_W-1:0]     residue_q, residue_d;
  logic [6:0]           res_bytes_q, res_bytes_d;
  logic                 one_beat_q, one_beat_d;
  logic [31:0]          drop_cnt_q, drop_cnt_d;
  logic [63:0]          cycle_q;

  logic [6:0] in_vbytes;
  logic       in_short;

  // Valid bytes in the incoming beat and whether they fit inside the header.
  assign in_vbytes = 7'(MAC_BYTES) - 7'(mac_parse_padbytes);
  assign in_short  = (in_vbytes <= 7'(ETH_HDR_BYTES));

  assign parse_dst_eth_hdr   = hdr_q;
  assign parse_dst_data_size = size_q;
  assign parse_dst_timestamp = ts_q;
  assign parse_drop_cnt      = drop_cnt_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_d     = state_q;
    hdr_d       = hdr_q;
    size_d      = size_q;
    ts_d        = ts_q;
    residue_d   = residue_q;
    res_bytes_d = res_bytes_q;
    one_beat_d  = one_beat_q;
    drop_cnt_d  = drop_cnt_q;

    parse_mac_rdy       = 1'b0;
    parse_dst_hdr_val   = 1'b0;
    parse_dst_data_val  = 1'b0;
    parse_dst_data      = {residue_q, mac_parse_data[MAC_INTERFACE_W-1 -: HDR_W]};
    parse_dst_data_last = 1'b0;
    parse_dst_padbytes  = '0;

    unique case (state_q)
      ST_IDLE: begin
        parse_mac_rdy = 1'b1;
        if (mac_parse_val) begin
          if (mac_parse_last && in_short) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
          end else begin
            hdr_d       = eth_hdr'(mac_parse_data[MAC_INTERFACE_W-1 -: HDR_W]);
            size_d      = mac_parse_frame_size - MTU_SIZE_W'(ETH_HDR_BYTES);
            ts_d        = tracker_stats_struct'(cycle_q[TS_W-1:0]);
            residue_d   = mac_parse_data[RES_W-1:0];
            res_bytes_d = in_vbytes - 7'(ETH_HDR_BYTES);
            one_beat_d  = mac_parse_last;
            state_d     = ST_HDR_OUT;
          end
        end
      end

      ST_HDR_OUT: begin
        parse_dst_hdr_val = 1'b1;
        if (dst_parse_hdr_rdy) state_d = one_beat_q ? ST_DRAIN : ST_DATA;
      end

      ST_DATA: begin
        // Upstream and downstream are joined combinationally; the beat carries
        // the 50 held bytes followed by the first 14 bytes of the new beat.
        parse_dst_data_val = mac_parse_val;
        parse_mac_rdy      = dst_parse_data_rdy;
        if (mac_parse_last && in_short) begin
          parse_dst_data_last = 1'b1;
          parse_dst_padbytes  = MAC_PADBYTES_W'(7'(ETH_HDR_BYTES) - in_vbytes);
        end
        if (mac_parse_val && dst_parse_data_rdy) begin
          residue_d = mac_parse_data[RES_W-1:0];
          if (mac_parse_last) begin
            if (in_short) begin
              state_d = ST_IDLE;
            end else begin
              res_bytes_d = in_vbytes - 7'(ETH_HDR_BYTES);
              state_d     = ST_DRAIN;
            end
          end
        end
      end

      ST_DRAIN: begin
        parse_dst_data_val  = 1'b1;
        parse_dst_data      = {residue_q, {HDR_W{1'b0}}};
        parse_dst_data_last = 1'b1;
        parse_dst_padbytes  = MAC_PADBYTES_W'(7'(MAC_BYTES) - res_bytes_q);
        if (dst_parse_data_rdy) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      size_q      <= '0;
      ts_q        <= '0;
      residue_q   <= '0;
      res_bytes_q <= '0;
      one_beat_q  <= 1'b0;
      drop_cnt_q  <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      size_q      <= size_d;
      ts_q        <= ts_d;
      residue_q   <= residue_d;
      res_bytes_q <= res_bytes_d;
      one_beat_q  <= one_beat_d;
      drop_cnt_q  <= drop_cnt_d;
      cycle_q     <= cycle_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_eth_frame_parser.sv
// Bench for eth_frame_parser: table of frame lengths with expected beat counts,
// scoreboard queues for header and payload bytes, backpressure and reset cases.
module tb_eth_frame_parser;
  import eth_parse_pkg::*;
  import packet_struct_pkg::*;
  import tracker_pkg::*;

  logic                       clk, rst;
  logic                       mac_parse_val, mac_parse_last;
  logic [MAC_INTERFACE_W-1:0] mac_parse_data;
  logic [MAC_PADBYTES_W-1:0]  mac_parse_padbytes;
  logic [MTU_SIZE_W-1:0]      mac_parse_frame_size;
  logic                       parse_mac_rdy;
  eth_hdr                     parse_dst_eth_hdr;
  logic [MTU_SIZE_W-1:0]      parse_dst_data_size;
  tracker_stats_struct        parse_dst_timestamp;
  logic                       parse_dst_hdr_val, dst_parse_hdr_rdy;
  logic                       parse_dst_data_val, parse_dst_data_last, dst_parse_data_rdy;
  logic [MAC_INTERFACE_W-1:0] parse_dst_data;
  logic [MAC_PADBYTES_W-1:0]  parse_dst_padbytes;
  logic [31:0]                parse_drop_cnt;

  eth_frame_parser dut (
    .clk                 (clk),
    .rst                 (rst),
    .mac_parse_val       (mac_parse_val),
    .mac_parse_data      (mac_parse_data),
    .mac_parse_last      (mac_parse_last),
    .mac_parse_padbytes  (mac_parse_padbytes),
    .mac_parse_frame_size(mac_parse_frame_size),
    .parse_mac_rdy       (parse_mac_rdy),
    .parse_dst_eth_hdr   (parse_dst_eth_hdr),
    .parse_dst_data_size (parse_dst_data_size),
    .parse_dst_timestamp (parse_dst_timestamp),
    .parse_dst_hdr_val   (parse_dst_hdr_val),
    .dst_parse_hdr_rdy   (dst_parse_hdr_rdy),
    .parse_dst_data_val  (parse_dst_data_val),
    .parse_dst_data      (parse_dst_data),
    .parse_dst_data_last (parse_dst_data_last),
    .parse_dst_padbytes  (parse_dst_padbytes),
    .dst_parse_data_rdy  (dst_parse_data_rdy),
    .parse_drop_cnt      (parse_drop_cnt)
  );

  typedef logic [7:0] byte_q_t[$];
  typedef struct { logic [7:0] b; bit last; } exp_byte_t;
  typedef struct { eth_hdr hdr; logic [MTU_SIZE_W-1:0] size; tracker_stats_struct ts; } exp_hdr_t;
  typedef struct { int len; int beats; int last_pad; int drop; } vec_t;

  exp_byte_t       exp_bytes[$];
  exp_hdr_t        exp_hdrs[$];
  vec_t            vecs[10];
  int              errors = 0;
  int              checks = 0;
  longint unsigned tb_cyc;
  bit              bp_en = 0;
  bit              abort = 0;
  int              hdrs_seen, beats_seen, last_pad_seen;
  bit              hdr_held, data_held;
  logic [575:0]    hdr_saved, data_saved;

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Reference cycle counter: restarts with reset, advances every clock.
  always @(posedge clk) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  initial begin
    dst_parse_hdr_rdy  = 1'b1;
    dst_parse_data_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dst_parse_hdr_rdy  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      dst_parse_data_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic mon_data_beat();
    int          n;
    logic [511:0] m, e;
    bit          exp_last, bad;
    exp_byte_t   eb;
    n = 64 - int'(parse_dst_padbytes);
    m = '0; e = '0; exp_last = 1'b0; bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (exp_bytes.size() == 0) begin
        bad = 1'b1;
        break;
      end
      eb = exp_bytes.pop_front();
      e[511-8*i -: 8] = eb.b;
      m[511-8*i -: 8] = 8'hFF;
      if (eb.last && i != n - 1) bad = 1'b1;
      if (i == n - 1) exp_last = eb.last;
    end
    check("payload_bytes", parse_dst_data & m, e);
    check("payload_last_order", {bad, parse_dst_data_last}, {1'b0, exp_last});
    beats_seen++;
    if (parse_dst_data_last) last_pad_seen = int'(parse_dst_padbytes);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hdr_held  = 1'b0;
      data_held = 1'b0;
    end else begin
      if (hdr_held)
        check("hdr_stall_stable", {parse_dst_hdr_val, parse_dst_eth_hdr, parse_dst_data_size,
                                   parse_dst_timestamp}, hdr_saved);
      if (data_held)
        check("data_stall_stable", {parse_dst_data_val, parse_dst_data_last, parse_dst_padbytes,
                                    parse_dst_data}, data_saved);
      if (parse_dst_data_val) check("data_while_hdr_pending", parse_dst_hdr_val, 0);
      if (parse_dst_hdr_val && dst_parse_hdr_rdy) begin
        hdrs_seen++;
        if (exp_hdrs.size() == 0) begin
          check("unexpected_hdr", 1, 0);
        end else begin
          exp_hdr_t eh;
          eh = exp_hdrs.pop_front();
          check("hdr_fields", parse_dst_eth_hdr, eh.hdr);
          check("hdr_data_size", parse_dst_data_size, eh.size);
          check("hdr_timestamp", parse_dst_timestamp, eh.ts);
        end
      end
      if (parse_dst_data_val && dst_parse_data_rdy) mon_data_beat();
      hdr_held   = parse_dst_hdr_val && !dst_parse_hdr_rdy;
      hdr_saved  = {parse_dst_hdr_val, parse_dst_eth_hdr, parse_dst_data_size, parse_dst_timestamp};
      data_held  = parse_dst_data_val && !dst_parse_data_rdy;
      data_saved = {parse_dst_data_val, parse_dst_data_last, parse_dst_padbytes, parse_dst_data};
    end
  end

  function automatic byte_q_t make_frame(input int len);
    byte_q_t fr;
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    return fr;
  endfunction

  task automatic send_frame(input byte_q_t fr);
    int           n, nb, v, waited;
    logic [511:0] d;
    logic [111:0] hv;
    exp_hdr_t     eh;
    n  = fr.size();
    nb = (n + 63) / 64;
    @(posedge clk);
    #1;
    for (int b = 0; b < nb; b++) begin
      v = (b == nb - 1) ? n - 64 * b : 64;
      d = {16{$urandom}};
      for (int i = 0; i < v; i++) d[511-8*i -: 8] = fr[64*b+i];
      mac_parse_data       = d;
      mac_parse_val        = 1'b1;
      mac_parse_last       = (b == nb - 1);
      mac_parse_padbytes   = MAC_PADBYTES_W'(64 - v);
      mac_parse_frame_size = MTU_SIZE_W'(n);
      waited = 0;
      forever begin
        @(negedge clk);
        if (abort) return;
        if (parse_mac_rdy) break;
        waited++;
        if (waited > 5000) begin
          check("upstream_accept_timeout", 1, 0);
          mac_parse_val = 1'b0;
          return;
        end
      end
      if (b == 0 && n > ETH_HDR_BYTES) begin
        hv = '0;
        for (int i = 0; i < ETH_HDR_BYTES; i++) hv = {hv[103:0], fr[i]};
        eh.hdr  = eth_hdr'(hv);
        eh.size = MTU_SIZE_W'(n - ETH_HDR_BYTES);
        eh.ts   = tracker_stats_struct'(tb_cyc[47:0]);
        exp_hdrs.push_back(eh);
        for (int i = ETH_HDR_BYTES; i < n; i++) exp_bytes.push_back('{fr[i], i == n - 1});
      end
      @(posedge clk);
      #1;
    end
    mac_parse_val  = 1'b0;
    mac_parse_last = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_bytes.size() != 0 || exp_hdrs.size() != 0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", w >= 5000, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    byte_q_t     fr;
    logic [31:0] drop0;
    drop0         = parse_drop_cnt;
    hdrs_seen     = 0;
    beats_seen    = 0;
    last_pad_seen = -1;
    fr = make_frame(v.len);
    send_frame(fr);
    wait_drain();
    check($sformatf("len%0d_beats", v.len), beats_seen, v.beats);
    check($sformatf("len%0d_hdrs", v.len), hdrs_seen, 1 - v.drop);
    check($sformatf("len%0d_last_pad", v.len), last_pad_seen, v.last_pad);
    check($sformatf("len%0d_drop_delta", v.len), parse_drop_cnt - drop0, v.drop);
  endtask

  initial begin
    byte_q_t big;
    int      w;
    vecs[0] = '{60,   1,  18, 0};
    vecs[1] = '{128,  2,  14, 0};
    vecs[2] = '{74,   1,   4, 0};
    vecs[3] = '{12,   0,  -1, 1};
    vecs[4] = '{14,   0,  -1, 1};
    vecs[5] = '{15,   1,  63, 0};
    vecs[6] = '{64,   1,  14, 0};
    vecs[7] = '{78,   1,   0, 0};
    vecs[8] = '{79,   2,  63, 0};
    vecs[9] = '{1518, 24, 32, 0};

    rst                  = 1'b1;
    mac_parse_val        = 1'b0;
    mac_parse_last       = 1'b0;
    mac_parse_data       = '0;
    mac_parse_padbytes   = '0;
    mac_parse_frame_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mac_rdy", parse_mac_rdy, 1);
    check("reset_hdr_val", parse_dst_hdr_val, 0);
    check("reset_data_val", parse_dst_data_val, 0);
    check("reset_drop_cnt", parse_drop_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    bp_en = 1'b1;
    for (int i = 0; i < 3; i++) run_vec(vecs[9]);
    run_vec(vecs[1]);
    bp_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a long frame's payload.
    beats_seen = 0;
    abort      = 1'b0;
    big        = make_frame(1518);
    fork
      send_frame(big);
    join_none
    w = 0;
    while (beats_seen < 3 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("rst_reach_data", beats_seen >= 3, 1);
    @(posedge clk);
    #2;
    abort         = 1'b1;
    rst           = 1'b1;
    mac_parse_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_mac_rdy", parse_mac_rdy, 1);
    check("midrst_hdr_val", parse_dst_hdr_val, 0);
    check("midrst_data_val", parse_dst_data_val, 0);
    check("midrst_drop_cnt", parse_drop_cnt, 0);
    exp_bytes.delete();
    exp_hdrs.delete();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    abort = 1'b0;
    run_vec(vecs[0]);
    run_vec(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
